// File: rtl/tile_slide_merge_if.sv
// Request/response bundle between a board controller and the 2048 move engine.
interface tile_slide_merge_if #(
    parameter int unsigned SCORE_W = 20
);
    logic               start;
    logic [1:0]         dir;
    logic [63:0]        board_in;
    logic               busy;
    logic               done;
    logic [63:0]        board_out;
    logic               moved;
    logic [SCORE_W-1:0] score_inc;

    modport master (
        output start, dir, board_in,
        input  busy, done, board_out, moved, score_inc
    );

    modport slave (
        input  start, dir, board_in,
        output busy, done, board_out, moved, score_inc
    );
endinterface

// File: rtl/tile_slide_merge.sv
// 2048 move engine: slides and merges one row/column per cycle, then reports
// the new board, whether anything moved and the score gained.
module tile_slide_merge #(
    parameter int unsigned MAX_CODE = 15,
    parameter int unsigned SCORE_W  = 20
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    tile_slide_merge_if.slave bus
);

    typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;

    state_t             state;
    logic [63:0]        work;
    logic [63:0]        orig;
    logic [1:0]         dir_q;
    logic [1:0]         line_q;
    logic               busy_q;
    logic               done_q;
    logic [63:0]        board_out_q;
    logic               moved_q;
    logic [SCORE_W-1:0] score_q;

    logic [3:0]         elem   [4];
    logic [3:0]         comp   [4];
    logic [3:0]         merged [4];
    logic [3:0]         result [4];
    logic [5:0]         bit_idx[4];
    logic [2:0]         cnt;
    logic               skip;
    logic [SCORE_W-1:0] line_score;
    logic [63:0]        work_nxt;

    // Cell p = 4*r + c; element 0 is the cell tiles slide toward.
    function automatic logic [3:0] cell_pos(input logic [1:0] d, input logic [1:0] ln,
                                            input logic [1:0] j);
        case (d)
            2'd0:    return {ln, j};
            2'd1:    return {ln, ~j};
            2'd2:    return {j, ln};
            default: return {~j, ln};
        endcase
    endfunction

    // Compress, merge each pair at most once, compress again, write back.
    always_comb begin
        elem       = '{default: '0};
        comp       = '{default: '0};
        result     = '{default: '0};
        bit_idx    = '{default: '0};
        cnt        = '0;
        skip       = 1'b0;
        line_score = '0;
        work_nxt   = work;

        for (int j = 0; j < 4; j++) begin
            bit_idx[j] = {~cell_pos(dir_q, line_q, 2'(j)), 2'b11};
            elem[j]    = work[bit_idx[j] -: 4];
        end

        for (int k = 0; k < 4; k++) begin
            if (elem[k] != 4'd0) begin
                comp[cnt[1:0]] = elem[k];
                cnt            = cnt + 3'd1;
            end
        end

        merged = comp;
        for (int j = 0; j < 3; j++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (merged[j] != 4'd0 && merged[j] == merged[j+1] &&
                         merged[j] < 4'(MAX_CODE)) begin
                line_score  = line_score + (SCORE_W'(1) << (merged[j] + 4'd1));
                merged[j]   = merged[j] + 4'd1;
                merged[j+1] = 4'd0;
                skip        = 1'b1;
            end
        end

        cnt = '0;
        for (int k = 0; k < 4; k++) begin
            if (merged[k] != 4'd0) begin
                result[cnt[1:0]] = merged[k];
                cnt              = cnt + 3'd1;
            end
        end

        for (int j = 0; j < 4; j++) begin
            work_nxt[bit_idx[j] -: 4] = result[j];
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state       <= IDLE;
            work        <= '0;
            orig        <= '0;
            dir_q       <= '0;
            line_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            board_out_q <= '0;
            moved_q     <= 1'b0;
            score_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        work    <= bus.board_in;
                        orig    <= bus.board_in;
                        dir_q   <= bus.dir;
                        line_q  <= '0;
                        score_q <= '0;
                        busy_q  <= 1'b1;
                        state   <= PROC;
                    end else begin
                        state <= IDLE;
                    end
                end
                PROC: begin
                    work    <= work_nxt;
                    score_q <= score_q + line_score;
                    line_q  <= line_q + 2'd1;
                    if (line_q == 2'd3) begin
                        board_out_q <= work_nxt;
                        moved_q     <= (work_nxt != orig);
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state       <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.board_out = board_out_q;
    assign bus.moved     = moved_q;
    assign bus.score_inc = score_q;

endmodule

// File: tb/tb_tile_slide_merge.sv
// Bench for tile_slide_merge: directed vector table, corner sequences and
// random boards against a queue-based model of the 2048 move rules.
module tb_tile_slide_merge;

    localparam int unsigned SCORE_W = 20;

    logic CLOCK_50 = 1'b0;
    logic reset;
    int   n_pass   = 0;
    int   n_checks = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    tile_slide_merge_if #(.SCORE_W(SCORE_W)) bus();

    tile_slide_merge #(.MAX_CODE(15), .SCORE_W(SCORE_W)) dut (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .bus     (bus)
    );

    typedef struct {
        string       name;
        logic [63:0] board;
        logic [1:0]  dir;
        logic [63:0] exp_board;
        logic        exp_moved;
        int unsigned exp_score;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int cell_index(input int d, input int i, input int j);
        int r, c;
        case (d)
            0:       begin r = i;     c = j;     end
            1:       begin r = i;     c = 3 - j; end
            2:       begin r = j;     c = i;     end
            default: begin r = 3 - j; c = i;     end
        endcase
        return 4 * r + c;
    endfunction

    // Reference: gather nonzero tiles of each line into a queue, pair them greedily.
    function automatic void model(input logic [63:0] b, input logic [1:0] d,
                                  output logic [63:0] nb, output int unsigned sc);
        int unsigned tiles[$];
        int unsigned outq[$];
        int unsigned a;
        int p;
        nb = b;
        sc = 0;
        for (int i = 0; i < 4; i++) begin
            tiles.delete();
            outq.delete();
            for (int j = 0; j < 4; j++) begin
                p = cell_index(int'(d), i, j);
                if (b[63-4*p -: 4] != 4'd0) tiles.push_back(int'(b[63-4*p -: 4]));
            end
            while (tiles.size() > 0) begin
                a = tiles.pop_front();
                if (tiles.size() > 0 && tiles[0] == a && a < 15) begin
                    void'(tiles.pop_front());
                    outq.push_back(a + 1);
                    sc += (1 << (a + 1));
                end else begin
                    outq.push_back(a);
                end
            end
            for (int j = 0; j < 4; j++) begin
                p = cell_index(int'(d), i, j);
                nb[63-4*p -: 4] = (j < outq.size()) ? 4'(outq[j]) : 4'd0;
            end
        end
    endfunction

    task automatic run_move(input logic [63:0] board, input logic [1:0] dir,
                            output logic [63:0] ob, output logic om,
                            output int unsigned os, output int lat, output logic busy1);
        @(negedge CLOCK_50);
        bus.board_in = board;
        bus.dir      = dir;
        bus.start    = 1'b1;
        @(negedge CLOCK_50);
        bus.start = 1'b0;
        busy1     = bus.busy;
        lat       = 0;
        while (!bus.done && lat < 12) begin
            @(negedge CLOCK_50);
            lat++;
        end
        ob = bus.board_out;
        om = bus.moved;
        os = 32'(bus.score_inc);
    endtask

    task automatic move_and_check(input string name, input logic [63:0] board,
                                  input logic [1:0] dir, input logic [63:0] exp_board,
                                  input logic exp_moved, input int unsigned exp_score);
        logic [63:0] ob;
        logic        om;
        int unsigned os;
        int          lat;
        logic        busy1;
        run_move(board, dir, ob, om, os, lat, busy1);
        check({name, ".busy"},    64'(busy1), 64'd1);
        check({name, ".latency"}, 64'(lat), 64'd4);
        check({name, ".board"},   ob, exp_board);
        check({name, ".moved"},   64'(om), 64'(exp_moved));
        check({name, ".score"},   64'(os), 64'(exp_score));
        @(negedge CLOCK_50);
        check({name, ".done_pulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        logic [63:0] rb;
        logic [63:0] eb;
        int unsigned es;
        logic [1:0]  rd;
        int          n_done;
        int          first;
        int          v;

        vecs[0] = '{"t1_left_quad",   64'h1111_0000_0000_0000, 2'd0, 64'h2200_0000_0000_0000, 1'b1, 8};
        vecs[1] = '{"t2_right",       64'h1012_0000_0000_0000, 2'd1, 64'h0022_0000_0000_0000, 1'b1, 4};
        vecs[2] = '{"t3_up",          64'h2000_2000_2000_0000, 2'd2, 64'h3000_2000_0000_0000, 1'b1, 8};
        vecs[3] = '{"t4_check_left",  64'h1212_2121_1212_2121, 2'd0, 64'h1212_2121_1212_2121, 1'b0, 0};
        vecs[4] = '{"t4_check_right", 64'h1212_2121_1212_2121, 2'd1, 64'h1212_2121_1212_2121, 1'b0, 0};
        vecs[5] = '{"t4_check_up",    64'h1212_2121_1212_2121, 2'd2, 64'h1212_2121_1212_2121, 1'b0, 0};
        vecs[6] = '{"t4_check_down",  64'h1212_2121_1212_2121, 2'd3, 64'h1212_2121_1212_2121, 1'b0, 0};
        vecs[7] = '{"t5_saturate",    64'hFF00_0000_0000_0000, 2'd0, 64'hFF00_0000_0000_0000, 1'b0, 0};

        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.dir      = 2'd0;
        bus.board_in = '0;
        repeat (3) @(negedge CLOCK_50);
        check("reset.busy",      64'(bus.busy), 64'd0);
        check("reset.done",      64'(bus.done), 64'd0);
        check("reset.board_out", bus.board_out, 64'd0);
        check("reset.moved",     64'(bus.moved), 64'd0);
        check("reset.score",     64'(bus.score_inc), 64'd0);
        reset = 1'b0;

        foreach (vecs[i])
            move_and_check(vecs[i].name, vecs[i].board, vecs[i].dir,
                           vecs[i].exp_board, vecs[i].exp_moved, vecs[i].exp_score);

        for (int n = 0; n < 40; n++) begin
            for (int p = 0; p < 16; p++) begin
                v = int'($urandom_range(0, 7));
                if (v < 3)       rb[63-4*p -: 4] = 4'd0;
                else if (v == 7) rb[63-4*p -: 4] = 4'($urandom_range(13, 15));
                else             rb[63-4*p -: 4] = 4'($urandom_range(1, 3));
            end
            rd = 2'($urandom_range(0, 3));
            model(rb, rd, eb, es);
            move_and_check("random", rb, rd, eb, eb != rb, es);
        end

        // Start held high while busy: only the first request is taken.
        @(negedge CLOCK_50);
        bus.board_in = 64'hFF00_0000_0000_0000;
        bus.dir      = 2'd0;
        bus.start    = 1'b1;
        n_done = 0;
        first  = -1;
        for (int c = 0; c < 16; c++) begin
            @(negedge CLOCK_50);
            if (c == 3) bus.start = 1'b0;
            if (bus.done) begin
                n_done++;
                if (first < 0) first = c;
            end
        end
        check("held_start.done_count", 64'(n_done), 64'd1);
        check("held_start.latency",    64'(first), 64'd4);
        check("held_start.board",      bus.board_out, 64'hFF00_0000_0000_0000);
        check("held_start.moved",      64'(bus.moved), 64'd0);

        // Reset on the second PROC cycle aborts the move.
        @(negedge CLOCK_50);
        bus.board_in = 64'h1111_0000_0000_0000;
        bus.dir      = 2'd0;
        bus.start    = 1'b1;
        @(negedge CLOCK_50);
        bus.start = 1'b0;
        @(negedge CLOCK_50);
        check("abort.mid_score", 64'(bus.score_inc), 64'd8);
        reset = 1'b1;
        @(negedge CLOCK_50);
        check("abort.busy",      64'(bus.busy), 64'd0);
        check("abort.board_out", bus.board_out, 64'd0);
        check("abort.score",     64'(bus.score_inc), 64'd0);
        reset  = 1'b0;
        n_done = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLOCK_50);
            if (bus.done) n_done++;
        end
        check("abort.no_done", 64'(n_done), 64'd0);

        move_and_check("after_abort", 64'h0000_0000_0000_1111, 2'd1,
                       64'h0000_0000_0000_0022, 1'b1, 8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
